// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target.
// Holds the FSM state type and the SPI mode decode table, which maps {CPOL, CPHA}
// to the SCLK edge on which MOSI is sampled.
package spi_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  // Bit i is 1 when mode i = {CPOL, CPHA} samples on the rising SCLK edge.
  // Modes 0 and 3 sample rising; modes 1 and 2 sample falling.
  localparam logic [3:0] SampleRiseByMode = 4'b1001;

  function automatic logic sample_on_rise(input int unsigned cpol, input int unsigned cpha);
    logic [1:0] mode;
    mode = {cpol[0], cpha[0]};
    return SampleRiseByMode[mode];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus rise/fall detection.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, forces every flop to RstVal
//   d_i     : asynchronous input
//   q_o     : synchronised level
//   rise_o  : one-cycle pulse when q_o goes 0->1
//   fall_o  : one-cycle pulse when q_o goes 1->0
module spi_sync_edge #(
  parameter int unsigned Stages = 2,
  parameter bit          RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{RstVal}};
      prev_q <= RstVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target (slave) with oversampled SCLK: every SPI pin is synchronised into iClk,
// and SCLK edges are detected as single-cycle strobes. iClk must be >= 8x SCLK.
//   iClk, iRstN        : system clock, asynchronous active-low reset
//   iSPIClk/CS/MOSI    : raw SPI pins (asynchronous)
//   oSPIMISO/En        : serial data out and its driver enable
//   oRx, oRxValid      : last complete received word and its one-cycle strobe
//   iTx/iTxValid/oTxReady : valid/ready load of the TX holding register
//   oTxUnderrun        : one-cycle strobe when a word starts with no TX data
//   oBusy              : chip select asserted (synchronised)
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iSPIClk,
  input  logic             iSPICS,
  input  logic             iSPIMOSI,
  output logic             oSPIMISO,
  output logic             oSPIMISOEn,
  output logic [WIDTH-1:0] oRx,
  output logic             oRxValid,
  input  logic [WIDTH-1:0] iTx,
  input  logic             iTxValid,
  output logic             oTxReady,
  output logic             oTxUnderrun,
  output logic             oBusy
);

  localparam int unsigned    CntW       = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit   = CntW'(WIDTH - 1);
  localparam bit             CpolBit    = (CPOL != 0);
  localparam bit             CphaBit    = (CPHA != 0);
  localparam bit             MsbFirst   = (MSB_FIRST != 0);
  localparam bit             SampleRise = sample_on_rise(CPOL, CPHA);

  // Synchronisers
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(
    .Stages(SYNC_STAGES),
    .RstVal(CpolBit)
  ) u_sync_sclk (
    .clk_i (iClk),
    .rst_ni(iRstN),
    .d_i   (iSPIClk),
    .q_o   (sclk_s),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(
    .Stages(SYNC_STAGES),
    .RstVal(1'b1)
  ) u_sync_cs (
    .clk_i (iClk),
    .rst_ni(iRstN),
    .d_i   (iSPICS),
    .q_o   (cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_sync_edge #(
    .Stages(SYNC_STAGES),
    .RstVal(1'b0)
  ) u_sync_mosi (
    .clk_i (iClk),
    .rst_ni(iRstN),
    .d_i   (iSPIMOSI),
    .q_o   (mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  // Only the MOSI level is used; SCLK level is only seen through its edge strobes.
  logic unused_sync;
  assign unused_sync = ^{mosi_rise, mosi_fall, sclk_s, cs_s};

  logic sample_edge, shift_edge;
  assign sample_edge = SampleRise ? sclk_rise : sclk_fall;
  assign shift_edge  = SampleRise ? sclk_fall : sclk_rise;

  // FSM: state register
  spi_state_e state_q, state_d;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  logic             busy;
  logic             miso;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;

  always_comb begin
    busy = 1'b0;
    miso = 1'b0;
    case (state_q)
      StActive: begin
        busy = 1'b1;
        miso = MsbFirst ? tx_shift_q[WIDTH-1] : tx_shift_q[0];
      end
      default: begin
        busy = 1'b0;
        miso = 1'b0;
      end
    endcase
  end

  // Datapath
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             rx_valid_q, rx_valid_d;
  logic             hold_full_q, hold_full_d;
  logic             underrun_q, underrun_d;
  logic             urun_pend_q, urun_pend_d;
  logic             skip_shift_q, skip_shift_d;
  logic [WIDTH-1:0] rx_next, tx_next;
  logic             xfer, xfer_deferred, tx_load;

  always_comb begin
    rx_next = MsbFirst ? {rx_shift_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift_q[WIDTH-1:1]};
    tx_next = MsbFirst ? {tx_shift_q[WIDTH-2:0], 1'b0} : {1'b0, tx_shift_q[WIDTH-1:1]};
  end

  assign tx_load = iTxValid & ~hold_full_q;

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_d          = rx_q;
    rx_valid_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    underrun_d    = 1'b0;
    urun_pend_d   = urun_pend_q;
    skip_shift_d  = skip_shift_q;
    xfer          = 1'b0;
    xfer_deferred = 1'b0;

    if (state_q == StIdle) begin
      bit_cnt_d    = '0;
      urun_pend_d  = 1'b0;
      skip_shift_d = 1'b0;
      // With CPHA=0 the first bit must be on MISO before the first SCLK edge.
      if (cs_fall && !CphaBit) xfer = 1'b1;
    end else if (cs_rise) begin
      // Abort: partial word dropped, holding register kept.
      bit_cnt_d    = '0;
      urun_pend_d  = 1'b0;
      skip_shift_d = 1'b0;
    end else begin
      if (sample_edge) begin
        rx_shift_d = rx_next;
        if (urun_pend_q) begin
          underrun_d  = 1'b1;
          urun_pend_d = 1'b0;
        end
        if (bit_cnt_q == LastBit) begin
          bit_cnt_d  = '0;
          rx_d       = rx_next;
          rx_valid_d = 1'b1;
          if (!CphaBit) begin
            // Load the next word now so its first bit is on MISO before the next
            // leading edge; the trailing edge that follows must not shift it away.
            // Underrun is only flagged once that next word is actually clocked.
            xfer          = 1'b1;
            xfer_deferred = 1'b1;
            skip_shift_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      if (shift_edge) begin
        if (CphaBit && (bit_cnt_q == '0)) begin
          xfer = 1'b1;
        end else if (skip_shift_q) begin
          skip_shift_d = 1'b0;
        end else begin
          tx_shift_d = tx_next;
        end
      end
    end

    // Transfer uses the old holding contents; a coincident load then refills it.
    if (xfer) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        if (xfer_deferred) begin
          urun_pend_d = 1'b1;
        end else begin
          underrun_d = 1'b1;
        end
      end
    end
    if (tx_load) begin
      hold_d      = iTx;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      rx_q         <= '0;
      rx_valid_q   <= 1'b0;
      tx_shift_q   <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      underrun_q   <= 1'b0;
      urun_pend_q  <= 1'b0;
      skip_shift_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      rx_q         <= rx_d;
      rx_valid_q   <= rx_valid_d;
      tx_shift_q   <= tx_shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      underrun_q   <= underrun_d;
      urun_pend_q  <= urun_pend_d;
      skip_shift_q <= skip_shift_d;
    end
  end

  assign oRx         = rx_q;
  assign oRxValid    = rx_valid_q;
  assign oTxReady    = ~hold_full_q;
  assign oTxUnderrun = underrun_q;
  assign oBusy       = busy;
  assign oSPIMISOEn  = busy;
  assign oSPIMISO    = miso;

endmodule
